// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 multiplier (low 16 bits) that borrows the execute-stage
// ALU adder for one accumulate step per RUN cycle.
module alu_mul_sequencer #(
    parameter logic [2:0] ADD_OPCODE = 3'b000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [15:0] i_multiplicand,
    input  logic [15:0] i_multiplier,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_product,
    output logic        o_aluReq,
    output logic [15:0] o_aluSrc1,
    output logic [15:0] o_aluSrc2,
    output logic [2:0]  o_aluOpcode,
    output logic        o_aluFlagBit,
    input  logic [15:0] i_aluResult
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e      state_q;
    logic [15:0] acc_q, mcand_q, mplier_q, product_q;
    logic [3:0]  count_q;
    logic        done_q, busy_q;

    logic [15:0] acc_d, mplier_d;
    logic        last_d;
    logic        run;

    assign run = (state_q == S_RUN);

    // Accumulate only when the current multiplier bit is set.
    always_comb begin
        acc_d    = mplier_q[0] ? i_aluResult : acc_q;
        mplier_d = {1'b0, mplier_q[15:1]};
        last_d   = (mplier_d == 16'd0) || (count_q == 4'd15);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        mcand_q  <= i_multiplicand;
                        mplier_q <= i_multiplier;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        // A zero operand skips the ALU entirely.
                        if (i_multiplicand == 16'd0 || i_multiplier == 16'd0) begin
                            state_q   <= S_DONE;
                            product_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= {mcand_q[14:0], 1'b0};
                    mplier_q <= mplier_d;
                    count_q  <= count_q + 4'd1;
                    if (last_d) begin
                        state_q   <= S_DONE;
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_product    = product_q;
    assign o_aluReq     = run;
    assign o_aluSrc1    = run ? acc_q   : 16'd0;
    assign o_aluSrc2    = run ? mcand_q : 16'd0;
    assign o_aluOpcode  = ADD_OPCODE;
    assign o_aluFlagBit = 1'b0;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 16x16 unsigned multiply (low 16 bits) by sequencing the shared ALU's adder through shift-and-add iterations.
- Sits beside the ALU in the execute stage and drives the ALU operand/opcode inputs while it owns the ALU.
- Decode/execute control starts a multiply with a start pulse, then waits for a done pulse.
- Products are truncated to the 16-bit register width.

Parameters:
- ADD_OPCODE, 3'b000, value driven on o_aluOpcode to select ALU integer addition.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_start  in  1  request a multiply; sampled only in IDLE.
- i_multiplicand  in  16  operand A, captured on accepted start.
- i_multiplier  in  16  operand B, captured on accepted start.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse; o_product is valid.
- o_product  out  16  registered low 16 bits of A*B; held until the next result.
- o_aluReq  out  1  high when the sequencer owns the ALU this cycle (RUN).
- o_aluSrc1  out  16  ALU operand 1 (accumulator).
- o_aluSrc2  out  16  ALU operand 2 (shifted multiplicand).
- o_aluOpcode  out  3  ALU opcode.
- o_aluFlagBit  out  1  ALU flag bit; always 0.
- i_aluResult  in  16  combinational ALU result, sampled in the same cycle.

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous and active-low (i_rstn).
- Reset values: state=IDLE; acc, mcand, mplier, count = 0; o_product=0; o_done=0; o_busy=0; o_aluReq=0.
- Reset mid-operation aborts immediately to the reset values; no done pulse is produced.
- State IDLE:
  - On an edge with i_start=1: mcand<=A, mplier<=B, acc<=0, count<=0.
  - If A==0 or B==0, go to DONE; the ALU is never requested. Otherwise go to RUN.
  - With i_start=0, stay in IDLE.
- State RUN:
  - Combinational outputs: o_aluReq=1, o_aluSrc1=acc, o_aluSrc2=mcand, o_aluOpcode=ADD_OPCODE, o_aluFlagBit=0.
  - At each edge: if mplier[0], acc<=i_aluResult, else acc holds. Then mcand<=mcand<<1 (bit 15 dropped), mplier<=mplier>>1, count<=count+1.
  - Go to DONE when (mplier>>1)==0 or count==15; otherwise stay in RUN.
- State DONE:
  - Lasts exactly one cycle; o_done=1.
  - o_product is loaded with the final acc on the edge entering DONE, so it is already valid during the DONE cycle.
  - Next state is IDLE.
- ALU interface outside RUN: o_aluReq=0, o_aluSrc1=0, o_aluSrc2=0, o_aluOpcode=ADD_OPCODE, o_aluFlagBit=0.
- Latency, counted from the start-sampling edge:
  - RUN lasts msb_index(B)+1 cycles (range 1..16), then 1 DONE cycle.
  - Zero operand: DONE is the first cycle after the start edge.
- i_start is ignored while o_busy=1, including the DONE cycle. A start in the first IDLE cycle after DONE is accepted (back-to-back).
- Operands are captured at start. Changes on i_multiplicand/i_multiplier afterward have no effect.
- Arithmetic is modulo 2^16; overflow is silently discarded with no flag.
- No combinational path from i_aluResult to any output other than through acc/o_product registers.

Test Plan:
- A=3, B=5: RUN cycles show (src1,src2) = (0,3), (3,6), (3,12). o_product=15 and o_done pulse in the 4th cycle after the start edge. o_aluReq high exactly 3 cycles.
- A=0x1234, B=0: o_done in the 1st cycle after start; o_product=0x0000; o_aluReq never asserted.
- A=0xFFFF, B=0xFFFF: 16 RUN cycles; o_product=0x0001 (modulo wrap); o_done in cycle 17.
- A=7, B=9: assert i_start every cycle while busy. Only one operation runs, o_product=63, and a new start the cycle after DONE (A=2, B=2) yields 4.
- A=0x0100, B=0x0300: drop i_rstn low in the 3rd RUN cycle. All outputs return asynchronously to the reset values, no o_done occurs, and a fresh A=6, B=7 then gives 42.
- A=0x8000, B=2: o_product=0x0000 (shifted-out bit discarded); RUN lasts 2 cycles.
